// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and helpers for the SRAM memory-stage controller.
package sram_pkg;

  // Wait counter width, wide enough for the largest legal WAIT.
  localparam int unsigned WAIT_W = $clog2(16);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Request attributes captured when an access is accepted.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } req_t;

  // Number of narrow SRAM beats per pipeline word.
  function automatic int unsigned beats(input int unsigned data_w, input int unsigned sram_dw);
    return data_w / sram_dw;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-cycle and beat counters for one multi-beat SRAM access.
module sram_beat_timer
  import sram_pkg::*;
#(
  parameter int unsigned BEATS  = 2,
  parameter int unsigned WAIT   = 5,
  parameter int unsigned BEAT_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  output logic [BEAT_W-1:0] beat,
  output logic              wait_last,
  output logic              beat_last,
  output logic              we_window
);

  logic [WAIT_W-1:0] wcnt;

  assign wait_last = (wcnt == WAIT_W'(WAIT - 1));
  assign beat_last = (beat == BEAT_W'(BEATS - 1));
  // Write strobe excludes the first and last cycle of a beat for setup/hold.
  assign we_window = (wcnt != '0) && (wcnt <= WAIT_W'(WAIT - 2));

  // Advance wcnt every cycle of an access; step beat when a beat completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      beat <= '0;
    end else if (start) begin
      wcnt <= '0;
      beat <= '0;
    end else if (run) begin
      if (wait_last) begin
        wcnt <= '0;
        beat <= beat_last ? '0 : beat + BEAT_W'(1);
      end else begin
        wcnt <= wcnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller that splits pipeline accesses into async SRAM beats.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SRAM_DW   = 16,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned WAIT      = 5,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] sram_dq,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int unsigned BEATS   = beats(DATA_W, SRAM_DW);
  localparam int unsigned BEAT_SH = $clog2(BEATS);
  localparam int unsigned BEAT_W  = (BEAT_SH == 0) ? 1 : BEAT_SH;

  state_t              state;
  state_t              state_nxt;
  req_t                req;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_any;
  logic                start;
  logic                run;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  dq_out;
  logic [BEAT_W-1:0]   beat;
  logic                wait_last;
  logic                beat_last;
  logic                we_window;

  // SRAM word address: word index above BASE_ADDR with the beat number appended.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [31:0] byte_addr,
                                                 input logic [BEAT_W-1:0] b);
    logic [31:0] word;
    word = (byte_addr - 32'(BASE_ADDR)) >> 2;
    return ADDR_W'((word << BEAT_SH) | 32'(b));
  endfunction

  assign req_any   = rd_en | wr_en;
  assign dq_out    = wdata_q[beat*SRAM_DW +: SRAM_DW];
  assign sram_dq   = dq_oe ? dq_out : 'z;
  assign sram_ub_n = sram_ce_n;
  assign sram_lb_n = sram_ce_n;

  sram_beat_timer #(
    .BEATS  (BEATS),
    .WAIT   (WAIT),
    .BEAT_W (BEAT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst),
    .start     (start),
    .run       (run),
    .beat      (beat),
    .wait_last (wait_last),
    .beat_last (beat_last),
    .we_window (we_window)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state, pipeline handshake and SRAM strobes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    run       = 1'b0;
    ready     = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req_any;
        if (req_any) begin
          state_nxt = ACCESS;
          start     = 1'b1;
        end
      end
      ACCESS: begin
        run       = 1'b1;
        sram_ce_n = 1'b0;
        if (req.wr) begin
          dq_oe     = 1'b1;
          sram_we_n = ~we_window;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (wait_last && beat_last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, SRAM address stepping and read-data assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req       <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      sram_addr <= '0;
    end else begin
      if (start) begin
        req       <= '{wr: wr_en, addr: address};
        wdata_q   <= wdata;
        sram_addr <= map_addr(address, '0);
      end
      if (run && wait_last && !req.wr) begin
        rdata[beat*SRAM_DW +: SRAM_DW] <= sram_dq;
      end
      if (run && wait_last && !beat_last) begin
        sram_addr <= map_addr(req.addr, beat + BEAT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl with behavioural async SRAM models.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration: 32-bit word, 16-bit SRAM, WAIT=5.
  logic        rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic [15:0] mem0 [0:1023];

  // 64-bit configuration with WAIT=3.
  logic        rd1, wr1;
  logic [31:0] addr1;
  logic [63:0] wd1, rdata1;
  logic        ready1;
  wire  [15:0] dq1;
  logic [17:0] sa1;
  logic        we1, oe1, ce1, ub1, lb1;
  logic [15:0] mem1 [0:1023];

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem0[sram_addr[9:0]] : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem0[sram_addr[9:0]] <= sram_dq;

  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[9:0]] : 16'bz;
  always @(posedge clk) if (!ce1 && !we1) mem1[sa1[9:0]] <= dq1;

  sram_mem_ctrl dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_dq(sram_dq),
    .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n),
    .sram_ce_n(ce_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  sram_mem_ctrl #(.DATA_W(64), .SRAM_DW(16), .ADDR_W(18), .WAIT(3), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
    .wdata(wd1), .rdata(rdata1), .ready(ready1), .sram_dq(dq1),
    .sram_addr(sa1), .sram_we_n(we1), .sram_oe_n(oe1),
    .sram_ce_n(ce1), .sram_ub_n(ub1), .sram_lb_n(lb1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access on dut0 starting from IDLE; ends with the controller back in IDLE.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd);
    int stall, we_lo, addr_err;
    logic [31:0] w;
    logic [17:0] ea;
    stall = 0; we_lo = 0; addr_err = 0;
    w = (a - 32'd1024) >> 2;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; wdata = wd;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; address = $urandom; wdata = $urandom;
      if (ready) break;
      stall++;
      if (!we_n) we_lo++;
      ea = 18'(w * 2 + 32'(c / 5));
      if (ce_n || ub_n || lb_n || sram_addr !== ea) addr_err++;
    end
    check("stall_cycles", 64'(stall), 64'd10);
    check("we_low_cycles", 64'(we_lo), wr ? 64'd6 : 64'd0);
    check("beat_addr_errors", 64'(addr_err), 64'd0);
    check("rdata_done", {32'd0, rdata}, sb.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic dut1_access(input logic rd, input logic wr, input logic [63:0] wd,
                             output int stall, output int we_lo);
    stall = 0; we_lo = 0;
    @(negedge clk);
    rd1 = rd; wr1 = wr; addr1 = 32'd1024; wd1 = wd;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      rd1 = 1'b0; wr1 = 1'b0; wd1 = {$urandom, $urandom};
      if (ready1) break;
      stall++;
      if (!we1) we_lo++;
    end
  endtask

  initial begin
    int st, wl;
    logic [17:0] exp_b2b [4];
    rst = 1'b0;
    rd_en = 0; wr_en = 0; address = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'd1024,          32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024,          32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'd1028,          32'h22221111, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'd1032,          32'h12345678, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'd1036,          32'hCAFEF00D, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'd1036,          32'h0,        32'hCAFEF00D};
    vecs[6]  = '{1'b1, 1'b0, 32'd1032,          32'h0,        32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 32'd1024 + 32'd524288, 32'hA5A55A5A, 32'h12345678};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024,          32'h0,        32'hA5A55A5A};
    vecs[9]  = '{1'b0, 1'b1, 32'd1020,          32'h0BADC0DE, 32'hA5A55A5A};
    vecs[10] = '{1'b1, 1'b0, 32'd1020,          32'h0,        32'h0BADC0DE};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_ce_n", 64'(ce_n), 64'd1);
    check("reset_strobes", {62'd0, we_n, oe_n}, 64'd3);
    check("reset_dq_z", 64'(sram_dq === 16'bz), 64'd1);
    check("reset_rdata", {32'd0, rdata}, 64'd0);
    check("reset_addr", 64'(sram_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table of single accesses on the default configuration.
    for (int i = 0; i < 11; i++) begin
      sb.push_back({32'd0, vecs[i].exp_rdata});
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      if (i == 0) begin
        check("mem0_beat0", 64'(mem0[0]), 64'hBEEF);
        check("mem0_beat1", 64'(mem0[1]), 64'hDEAD);
      end
    end
    check("mem0_wrap_lo", 64'(mem0[0]), 64'h5A5A);
    check("mem0_wrap_hi", 64'(mem0[1]), 64'hA5A5);
    check("mem0_both_lo", 64'(mem0[6]), 64'hF00D);
    check("mem0_below_base", 64'(mem0[1022]), 64'hC0DE);

    // Back-to-back reads: request held through the first DONE.
    exp_b2b[0] = 18'd2; exp_b2b[1] = 18'd3; exp_b2b[2] = 18'd2; exp_b2b[3] = 18'd3;
    sb.push_back(64'h22221111);
    sb.push_back(64'h22221111);
    @(negedge clk);
    rd_en = 1'b1; address = 32'd1028;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      check("b2b_ready", 64'(ready), 64'(k == 11 || k >= 23));
      if (k == 11 || k == 23) check("b2b_rdata", {32'd0, rdata}, sb.pop_front());
      if (k == 1)  check("b2b_addr", 64'(sram_addr), 64'(exp_b2b[0]));
      if (k == 6)  check("b2b_addr", 64'(sram_addr), 64'(exp_b2b[1]));
      if (k == 13) check("b2b_addr", 64'(sram_addr), 64'(exp_b2b[2]));
      if (k == 18) check("b2b_addr", 64'(sram_addr), 64'(exp_b2b[3]));
      if (k == 23) rd_en = 1'b0;
    end

    // Wide configuration: 4 beats of 3 cycles each.
    dut1_access(1'b0, 1'b1, 64'h0123456789ABCDEF, st, wl);
    check("w64_stall", 64'(st), 64'd12);
    check("w64_we_low", 64'(wl), 64'd4);
    check("w64_rdata_kept", rdata1, 64'd0);
    check("w64_mem0", 64'(mem1[0]), 64'hCDEF);
    check("w64_mem1", 64'(mem1[1]), 64'h89AB);
    check("w64_mem2", 64'(mem1[2]), 64'h4567);
    check("w64_mem3", 64'(mem1[3]), 64'h0123);
    @(posedge clk); #1;
    dut1_access(1'b1, 1'b0, 64'h0, st, wl);
    check("w64_rd_stall", 64'(st), 64'd12);
    check("w64_rdata", rdata1, 64'h0123456789ABCDEF);
    @(posedge clk); #1;

    // Reset asserted at wcnt=2 of beat 1 of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; wdata = 32'h55AA33CC;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    check("mid_we_active", 64'(we_n), 64'd0);
    #1 rst = 1'b0;
    #1;
    check("rst_ce_n", 64'(ce_n), 64'd1);
    check("rst_we_oe", {62'd0, we_n, oe_n}, 64'd3);
    check("rst_dq_z", 64'(sram_dq === 16'bz), 64'd1);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Idle with wiggling inputs but no request.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      wdata = $urandom; address = $urandom;
      @(posedge clk); #1;
      check("idle_ready", 64'(ready), 64'd1);
      check("idle_ce_n", 64'(ce_n), 64'd1);
      check("idle_dq_z", 64'(sram_dq === 16'bz), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
